mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Sequencing controller for the EXE→MEM pipeline register. Each cycle it decides whether the MEM register loads the EXE instruction (MEM_Wr), loads a bubble (MEM_Flush), or holds.
- It stalls EXE for data-cache misses.
- It serialises TLBP/TLBR/TLBW against the TLB unit and requests a refetch after TLBR/TLBW.
- It inserts post-exception bubbles.
- It sits beside the MEM register, between hazard/exception logic and the D-cache/TLB units.

## Interface
Parameters:
- REFETCH_BUBBLES, 2: bubble cycles in REFETCH state (must be ≥1).
- EXC_BUBBLES, 1: bubble cycles in EXC_FLUSH state (must be ≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, asynchronous, active-low.
- EXE_Valid  in  1  EXE holds a real instruction.
- EXE_MultiBusy  in  1  multi-cycle EXE unit not finished.
- EXE_IsTLBP, EXE_IsTLBW, EXE_IsTLBR  in  1 each  TLB op in EXE (one-hot or zero).
- MEM_ExcValid  in  1  exception committed by the instruction in MEM.
- DCache_Busy  in  1  D-cache cannot complete the MEM access this cycle.
- TLB_Done  in  1  TLB unit finished the requested op.
- MEM_Wr  out  1  load EXE values into MEM register.
- MEM_Flush  out  1  clear MEM register (bubble).
- EXE_Stall  out  1  hold IF/ID/EXE.
- TLB_Start  out  1  one-cycle TLB op request.
- Refetch_Req  out  1  one-cycle request to flush younger instructions and refetch at MEM_PC+4.
- MEM_Valid  out  1  MEM register holds a valid instruction (registered).
- Ctrl_State  out  3  encoded state: RUN=0, DC_WAIT=1, TLB_EXEC=2, REFETCH=3, EXC_FLUSH=4.

## Operation
- Registered state:
  - state (reset RUN)
  - MEM_Valid (reset 0)
  - bubble counter cnt (reset 0)
  - tlb_kind ∈ {P, W, R} (reset P)
  - tlb_issued flag (reset 0)
- While rst=0, the combinational outputs are MEM_Flush=1, MEM_Wr=0, EXE_Stall=0, TLB_Start=0 and Refetch_Req=0. This state is entered immediately, including mid-TLB or mid-refetch.
- **Advance rule A**, evaluated in priority order:
  - EXE_Valid & !EXE_MultiBusy & TLB op: MEM_Wr=1. Latch tlb_kind, clear tlb_issued, next state TLB_EXEC.
  - EXE_Valid & !EXE_MultiBusy: MEM_Wr=1.
  - Otherwise: MEM_Flush=1 (bubble).
- **RUN**, in priority order:
  1. MEM_Valid & MEM_ExcValid: MEM_Flush=1, cnt←EXC_BUBBLES−1, next state EXC_FLUSH.
  2. MEM_Valid & DCache_Busy: MEM_Wr=0, MEM_Flush=0, EXE_Stall=1, next state DC_WAIT.
  3. Otherwise: rule A.
- **DC_WAIT**:
  - MEM_ExcValid has priority, same as RUN item 1.
  - While DCache_Busy: hold, EXE_Stall=1.
  - When DCache_Busy=0: EXE_Stall=0, apply rule A in the same cycle, next state RUN (or TLB_EXEC if rule A selects it).
- **TLB_EXEC**:
  - EXE_Stall=1 and MEM_Wr=0 every cycle.
  - TLB_Start=!tlb_issued; tlb_issued←1.
  - MEM_ExcValid is ignored.
  - On TLB_Done:
    - tlb_kind=P: EXE_Stall=0, apply rule A.
    - tlb_kind=W or R: MEM_Flush=1, Refetch_Req=1, cnt←REFETCH_BUBBLES−1, next state REFETCH.
  - TLB_Done in the same cycle as TLB_Start is accepted.
- **REFETCH**:
  - MEM_Flush=1 and EXE_Stall=0; EXE inputs are ignored.
  - When cnt=0, next state RUN; otherwise cnt−1.
- **EXC_FLUSH**: same as REFETCH (bubbles, counter), then RUN.
- MEM_Valid at each posedge:
  - MEM_Flush → 0
  - else MEM_Wr → 1
  - else hold
- MEM_Wr and MEM_Flush are never both 1.
- TLB_Done outside TLB_EXEC is ignored.

## Timing
- All decisions are combinational from state and inputs; state updates on the rising edge.
- Normal throughput is one instruction per cycle. Latency EXE→MEM is 1 cycle.
- TLB op occupancy:
  - TLBP: TLB latency + 0 bubble cycles.
  - TLBW/TLBR: TLB latency + 1 + REFETCH_BUBBLES bubble cycles.
- Exception: 1 + EXC_BUBBLES bubble cycles.
- Refetch_Req and TLB_Start are exactly 1 cycle per op.

## Test plan
- **Reset**: hold rst=0 for 3 cycles with EXE_Valid=1, then release. During reset: MEM_Flush=1, MEM_Valid=0, Ctrl_State=0. First cycle after release: MEM_Wr=1. Next cycle: MEM_Valid=1.
- **D-cache miss**:
  - Stimulus: MEM_Valid=1, DCache_Busy=1 for 4 cycles.
  - EXE_Stall=1 and MEM_Wr=0 for exactly 4 cycles, Ctrl_State=1.
  - 5th cycle: EXE_Stall=0, MEM_Wr=1.
- **TLBW**:
  - Stimulus: EXE_IsTLBW with EXE_Valid=1; TLB_Done asserted 3 cycles after TLB_Start.
  - TLB_Start is a single pulse in the first TLB_EXEC cycle.
  - EXE_Stall=1 for 4 cycles.
  - On the Done cycle: Refetch_Req=1 and MEM_Flush=1.
  - Then 2 REFETCH cycles, then RUN.
- **TLBP with immediate Done**: TLB_Done in the first TLB_EXEC cycle → advance via rule A in that cycle, no Refetch_Req, next state RUN.
- **Simultaneous events**: MEM_ExcValid=1 and DCache_Busy=1 together in RUN → MEM_Flush=1, no stall, 1 EXC_FLUSH cycle, then RUN.
- **EXE busy**: EXE_MultiBusy=1 for 5 cycles → MEM_Flush=1 each cycle and MEM_Valid=0. Busy drop with EXE_Valid=1 → MEM_Wr=1.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Handshake bundle between the EXE->MEM sequencing controller and the pipeline,
// D-cache and TLB units around it.
interface mem_stage_ctrl_if;
  logic       EXE_Valid;
  logic       EXE_MultiBusy;
  logic       EXE_IsTLBP;
  logic       EXE_IsTLBW;
  logic       EXE_IsTLBR;
  logic       MEM_ExcValid;
  logic       DCache_Busy;
  logic       TLB_Done;
  logic       MEM_Wr;
  logic       MEM_Flush;
  logic       EXE_Stall;
  logic       TLB_Start;
  logic       Refetch_Req;
  logic       MEM_Valid;
  logic [2:0] Ctrl_State;

  // Controller side: consumes pipeline status, produces MEM register control.
  modport master (
    input  EXE_Valid, EXE_MultiBusy, EXE_IsTLBP, EXE_IsTLBW, EXE_IsTLBR,
    input  MEM_ExcValid, DCache_Busy, TLB_Done,
    output MEM_Wr, MEM_Flush, EXE_Stall, TLB_Start, Refetch_Req,
    output MEM_Valid, Ctrl_State
  );

  // Pipeline side: supplies status, obeys MEM register control.
  modport slave (
    output EXE_Valid, EXE_MultiBusy, EXE_IsTLBP, EXE_IsTLBW, EXE_IsTLBR,
    output MEM_ExcValid, DCache_Busy, TLB_Done,
    input  MEM_Wr, MEM_Flush, EXE_Stall, TLB_Start, Refetch_Req,
    input  MEM_Valid, Ctrl_State
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// EXE->MEM pipeline register sequencer: chooses load / bubble / hold each cycle,
// stalls for D-cache misses, serialises TLB ops and inserts post-exception bubbles.
module mem_stage_ctrl #(
  parameter int REFETCH_BUBBLES = 2,
  parameter int EXC_BUBBLES     = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_DC_WAIT   = 3'd1,
    ST_TLB_EXEC  = 3'd2,
    ST_REFETCH   = 3'd3,
    ST_EXC_FLUSH = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TLB_P = 2'd0,
    TLB_W = 2'd1,
    TLB_R = 2'd2
  } tlb_kind_e;

  localparam int CNT_MAX = (REFETCH_BUBBLES > EXC_BUBBLES) ? REFETCH_BUBBLES : EXC_BUBBLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] REF_LOAD = CNT_W'(REFETCH_BUBBLES - 1);
  localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXC_BUBBLES - 1);

  state_e            state_r;
  state_e            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  tlb_kind_e         tlb_kind_r;
  tlb_kind_e         tlb_kind_nxt_s;
  logic              tlb_issued_r;
  logic              tlb_issued_nxt_s;
  logic              mem_valid_r;

  logic              mem_wr_s;
  logic              mem_flush_s;
  logic              exe_stall_s;
  logic              tlb_start_s;
  logic              refetch_req_s;
  logic              apply_a_s;
  logic              adv_ok_s;
  logic              tlb_op_s;
  tlb_kind_e         tlb_kind_in_s;

  assign adv_ok_s = bus.EXE_Valid & ~bus.EXE_MultiBusy;
  assign tlb_op_s = bus.EXE_IsTLBP | bus.EXE_IsTLBW | bus.EXE_IsTLBR;

  // Decode which TLB op sits in EXE (inputs are one-hot or zero).
  always_comb begin
    if (bus.EXE_IsTLBW) begin
      tlb_kind_in_s = TLB_W;
    end else if (bus.EXE_IsTLBR) begin
      tlb_kind_in_s = TLB_R;
    end else begin
      tlb_kind_in_s = TLB_P;
    end
  end

  // Per-cycle load/bubble/hold decision and next-state computation.
  always_comb begin
    mem_wr_s         = 1'b0;
    mem_flush_s      = 1'b0;
    exe_stall_s      = 1'b0;
    tlb_start_s      = 1'b0;
    refetch_req_s    = 1'b0;
    apply_a_s        = 1'b0;
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    tlb_kind_nxt_s   = tlb_kind_r;
    tlb_issued_nxt_s = tlb_issued_r;

    case (state_r)
      ST_RUN: begin
        if (mem_valid_r & bus.MEM_ExcValid) begin
          mem_flush_s = 1'b1;
          cnt_nxt_s   = EXC_LOAD;
          state_nxt_s = ST_EXC_FLUSH;
        end else if (mem_valid_r & bus.DCache_Busy) begin
          exe_stall_s = 1'b1;
          state_nxt_s = ST_DC_WAIT;
        end else begin
          apply_a_s = 1'b1;
        end
      end
      ST_DC_WAIT: begin
        if (mem_valid_r & bus.MEM_ExcValid) begin
          mem_flush_s = 1'b1;
          cnt_nxt_s   = EXC_LOAD;
          state_nxt_s = ST_EXC_FLUSH;
        end else if (bus.DCache_Busy) begin
          exe_stall_s = 1'b1;
        end else begin
          apply_a_s = 1'b1;
        end
      end
      ST_TLB_EXEC: begin
        // The TLB instruction stays in MEM until the unit reports completion.
        exe_stall_s      = 1'b1;
        tlb_start_s      = ~tlb_issued_r;
        tlb_issued_nxt_s = 1'b1;
        if (bus.TLB_Done) begin
          if (tlb_kind_r == TLB_P) begin
            exe_stall_s = 1'b0;
            apply_a_s   = 1'b1;
          end else begin
            mem_flush_s   = 1'b1;
            refetch_req_s = 1'b1;
            cnt_nxt_s     = REF_LOAD;
            state_nxt_s   = ST_REFETCH;
          end
        end else begin
          state_nxt_s = ST_TLB_EXEC;
        end
      end
      ST_REFETCH, ST_EXC_FLUSH: begin
        mem_flush_s = 1'b1;
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        mem_flush_s = 1'b1;
        state_nxt_s = ST_RUN;
      end
    endcase

    // Advance rule: load a ready EXE instruction, otherwise insert a bubble.
    if (apply_a_s) begin
      state_nxt_s = ST_RUN;
      if (adv_ok_s) begin
        mem_wr_s = 1'b1;
        if (tlb_op_s) begin
          tlb_kind_nxt_s   = tlb_kind_in_s;
          tlb_issued_nxt_s = 1'b0;
          state_nxt_s      = ST_TLB_EXEC;
        end else begin
          tlb_kind_nxt_s = tlb_kind_r;
        end
      end else begin
        mem_flush_s = 1'b1;
      end
    end else begin
      apply_a_s = 1'b0;
    end

    // Reset overrides everything immediately, whatever state was in flight.
    if (!rst) begin
      mem_wr_s      = 1'b0;
      mem_flush_s   = 1'b1;
      exe_stall_s   = 1'b0;
      tlb_start_s   = 1'b0;
      refetch_req_s = 1'b0;
    end else begin
      mem_flush_s = mem_flush_s & ~mem_wr_s;
    end
  end

  // Sequencer state, bubble counter, TLB bookkeeping and MEM validity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_RUN;
      cnt_r        <= CNT_ZERO;
      tlb_kind_r   <= TLB_P;
      tlb_issued_r <= 1'b0;
      mem_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      tlb_kind_r   <= tlb_kind_nxt_s;
      tlb_issued_r <= tlb_issued_nxt_s;
      if (mem_flush_s) begin
        mem_valid_r <= 1'b0;
      end else if (mem_wr_s) begin
        mem_valid_r <= 1'b1;
      end else begin
        mem_valid_r <= mem_valid_r;
      end
    end
  end

  assign bus.MEM_Wr      = mem_wr_s;
  assign bus.MEM_Flush   = mem_flush_s;
  assign bus.EXE_Stall   = exe_stall_s;
  assign bus.TLB_Start   = tlb_start_s;
  assign bus.Refetch_Req = refetch_req_s;
  assign bus.MEM_Valid   = mem_valid_r;
  assign bus.Ctrl_State  = state_r;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed-vector bench for mem_stage_ctrl: the driver queues the expected
// outputs of every cycle it drives, and a monitor compares them at the falling edge.
module tb_mem_stage_ctrl;

  logic clk;
  logic rst;

  mem_stage_ctrl_if bus_if ();

  mem_stage_ctrl #(
    .REFETCH_BUBBLES(2),
    .EXC_BUBBLES    (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  // Expected outputs packed as {wr, flush, stall, tlb_start, refetch, mem_valid, state[2:0]}.
  logic [8:0] exp_q[$];
  string      name_q[$];
  int         n_checks;
  int         n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs packed as {rst, ev, mb, tlbp, tlbw, tlbr, exc, dcb, done}.
  task automatic step(input string name, input logic [8:0] in_v, input logic [8:0] exp_v);
    @(posedge clk);
    #1;
    rst                  = in_v[8];
    bus_if.EXE_Valid     = in_v[7];
    bus_if.EXE_MultiBusy = in_v[6];
    bus_if.EXE_IsTLBP    = in_v[5];
    bus_if.EXE_IsTLBW    = in_v[4];
    bus_if.EXE_IsTLBR    = in_v[3];
    bus_if.MEM_ExcValid  = in_v[2];
    bus_if.DCache_Busy   = in_v[1];
    bus_if.TLB_Done      = in_v[0];
    exp_q.push_back(exp_v);
    name_q.push_back(name);
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [8:0] e;
      logic [8:0] a;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {bus_if.MEM_Wr, bus_if.MEM_Flush, bus_if.EXE_Stall, bus_if.TLB_Start,
            bus_if.Refetch_Req, bus_if.MEM_Valid, bus_if.Ctrl_State};
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL %s: got wr/fl/st/ts/rf/mv/state=%b expected %b", nm, a, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst                  = 1'b0;
    bus_if.EXE_Valid     = 1'b0;
    bus_if.EXE_MultiBusy = 1'b0;
    bus_if.EXE_IsTLBP    = 1'b0;
    bus_if.EXE_IsTLBW    = 1'b0;
    bus_if.EXE_IsTLBR    = 1'b0;
    bus_if.MEM_ExcValid  = 1'b0;
    bus_if.DCache_Busy   = 1'b0;
    bus_if.TLB_Done      = 1'b0;

    for (int i = 0; i < 3; i++) step("rst_hold", 9'b0_10_000_00_0, 9'b01000_0_000);
    step("rst_release", 9'b1_10_000_00_0, 9'b10000_0_000);
    step("rst_mv",      9'b1_10_000_00_0, 9'b10000_1_000);

    step("dc_miss1",    9'b1_10_000_01_0, 9'b00100_1_000);
    for (int i = 0; i < 3; i++) step("dc_miss_wait", 9'b1_10_000_01_0, 9'b00100_1_001);
    step("dc_resume",   9'b1_10_000_00_0, 9'b10000_1_001);
    step("dc_after",    9'b1_10_000_00_0, 9'b10000_1_000);

    step("busy1",       9'b1_11_000_00_0, 9'b01000_1_000);
    for (int i = 0; i < 4; i++) step("busy_n", 9'b1_11_000_00_0, 9'b01000_0_000);
    step("busy_drop",   9'b1_10_000_00_0, 9'b10000_0_000);
    step("idle",        9'b1_00_000_00_0, 9'b01000_1_000);

    step("tlbw_issue",  9'b1_10_010_00_0, 9'b10000_0_000);
    step("tlbw_start",  9'b1_10_000_00_0, 9'b00110_1_010);
    step("tlbw_wait1",  9'b1_10_000_00_0, 9'b00100_1_010);
    step("tlbw_wait2",  9'b1_10_000_00_0, 9'b00100_1_010);
    step("tlbw_done",   9'b1_10_000_00_1, 9'b01101_1_010);
    step("tlbw_ref1",   9'b1_10_000_00_0, 9'b01000_0_011);
    step("tlbw_ref2",   9'b1_10_000_00_0, 9'b01000_0_011);
    step("stray_done",  9'b1_10_000_00_1, 9'b10000_0_000);

    step("tlbp_issue",  9'b1_10_100_00_0, 9'b10000_1_000);
    step("tlbp_done",   9'b1_10_000_00_1, 9'b10010_1_010);
    step("tlbp_run",    9'b1_10_000_00_0, 9'b10000_1_000);

    step("tlbr_issue",  9'b1_10_001_00_0, 9'b10000_1_000);
    step("tlbr_start",  9'b1_10_000_00_0, 9'b00110_1_010);
    step("tlbr_done",   9'b1_10_000_10_1, 9'b01101_1_010);
    step("tlbr_ref1",   9'b1_10_000_10_0, 9'b01000_0_011);
    step("tlbr_ref2",   9'b1_10_000_00_0, 9'b01000_0_011);
    step("tlbr_run",    9'b1_10_000_00_0, 9'b10000_0_000);

    step("sim_exc_dc",  9'b1_10_000_11_0, 9'b01000_1_000);
    step("exc_flush",   9'b1_10_000_00_0, 9'b01000_0_100);
    step("exc_run",     9'b1_10_000_00_0, 9'b10000_0_000);
    step("exc_run2",    9'b1_10_000_00_0, 9'b10000_1_000);

    step("dcw_miss",    9'b1_10_000_01_0, 9'b00100_1_000);
    step("dcw_exc",     9'b1_10_000_11_0, 9'b01000_1_001);
    step("dcw_flush",   9'b1_10_000_00_0, 9'b01000_0_100);
    step("dcw_idle",    9'b1_00_000_00_0, 9'b01000_0_000);

    step("mid_issue",   9'b1_10_010_00_0, 9'b10000_0_000);
    step("mid_start",   9'b1_10_000_00_0, 9'b00110_1_010);
    step("mid_rst",     9'b0_10_000_00_1, 9'b01000_0_000);
    step("mid_release", 9'b1_10_000_00_0, 9'b10000_0_000);
    step("mid_after",   9'b1_00_000_00_0, 9'b01000_1_000);

    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
